// File: rtl/alu_rf_sequencer.sv
// alu_rf_sequencer
//   Command-driven load/execute engine wrapped around a 4-entry register file
//   and a 32-bit ALU. Each accepted command is either a load-immediate
//   (IDLE -> WRITE) or an ALU operation Rdst <- Rsrc1 op Rsrc2
//   (IDLE -> READ -> EXEC -> WRITE). Results and flags are kept for software,
//   an overflow sticky bit collects ALU overflows and a counter tracks
//   completed commands.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid / cmd_ready       command handshake (ready only in IDLE)
//   cmd_type                    0 = load immediate, 1 = ALU op
//   cmd_src1/src2/dst, cmd_op   register addresses and ALU control code
//   cmd_imm, cmd_nowb           load immediate, ALU writeback suppression
//   rf_addr1/2/3, rf_data3      regfile read/write addresses and write data
//   rf_wr                       regfile write enable (one cycle, WRITE only)
//   alu_control                 ALU control code
//   alu_result/zero/overflow    combinational ALU outputs
//   done                        one-cycle completion pulse
//   res_data/zero/overflow      last result and flags
//   sticky_ovf, clr_sticky      accumulated overflow flag and its clear
//   ops_done                    completed-command counter (wraps)
module alu_rf_sequencer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_type,
   input  logic [ADDR_W-1:0] cmd_src1,
   input  logic [ADDR_W-1:0] cmd_src2,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [2:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_imm,
   input  logic              cmd_nowb,
   output logic [ADDR_W-1:0] rf_addr1,
   output logic [ADDR_W-1:0] rf_addr2,
   output logic [ADDR_W-1:0] rf_addr3,
   output logic [DATA_W-1:0] rf_data3,
   output logic              rf_wr,
   output logic [2:0]        alu_control,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   output logic              done,
   output logic [DATA_W-1:0] res_data,
   output logic              res_zero,
   output logic              res_overflow,
   output logic              sticky_ovf,
   input  logic              clr_sticky,
   output logic [CNT_W-1:0]  ops_done
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   state_t              state_q, state_d;
   logic                type_q, type_d;
   logic                nowb_q, nowb_d;
   logic [ADDR_W-1:0]   addr1_q, addr1_d;
   logic [ADDR_W-1:0]   addr2_q, addr2_d;
   logic [ADDR_W-1:0]   addr3_q, addr3_d;
   logic [2:0]          ctrl_q, ctrl_d;
   logic [DATA_W-1:0]   data3_q, data3_d;
   logic [DATA_W-1:0]   res_data_q, res_data_d;
   logic                res_zero_q, res_zero_d;
   logic                res_ovf_q, res_ovf_d;
   logic                sticky_q, sticky_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         type_q     <= 1'b0;
         nowb_q     <= 1'b0;
         addr1_q    <= '0;
         addr2_q    <= '0;
         addr3_q    <= '0;
         ctrl_q     <= '0;
         data3_q    <= '0;
         res_data_q <= '0;
         res_zero_q <= 1'b0;
         res_ovf_q  <= 1'b0;
         sticky_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         type_q     <= type_d;
         nowb_q     <= nowb_d;
         addr1_q    <= addr1_d;
         addr2_q    <= addr2_d;
         addr3_q    <= addr3_d;
         ctrl_q     <= ctrl_d;
         data3_q    <= data3_d;
         res_data_q <= res_data_d;
         res_zero_q <= res_zero_d;
         res_ovf_q  <= res_ovf_d;
         sticky_q   <= sticky_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      type_d     = type_q;
      nowb_d     = nowb_q;
      addr1_d    = addr1_q;
      addr2_d    = addr2_q;
      addr3_d    = addr3_q;
      ctrl_d     = ctrl_q;
      data3_d    = data3_q;
      res_data_d = res_data_q;
      res_zero_d = res_zero_q;
      res_ovf_d  = res_ovf_q;
      sticky_d   = sticky_q;
      cnt_d      = cnt_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               type_d  = cmd_type;
               // nowb only has meaning for ALU ops; a load always writes
               nowb_d  = cmd_type & cmd_nowb;
               addr1_d = cmd_src1;
               addr2_d = cmd_src2;
               addr3_d = cmd_dst;
               ctrl_d  = cmd_op;
               if (cmd_type) begin
                  state_d = READ;
               end else begin
                  data3_d = cmd_imm;
                  state_d = WRITE;
               end
            end
         end
         READ: begin
            // one cycle for the regfile read and ALU to settle on the latched addresses
            state_d = EXEC;
         end
         EXEC: begin
            data3_d    = alu_result;
            res_data_d = alu_result;
            res_zero_d = alu_zero;
            res_ovf_d  = alu_overflow;
            state_d    = WRITE;
         end
         WRITE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!type_q) begin
               res_data_d = data3_q;
               res_zero_d = 1'b0;
               res_ovf_d  = 1'b0;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // a fresh overflow capture outranks a clear requested in the same cycle
      if (state_q == EXEC && alu_overflow) begin
         sticky_d = 1'b1;
      end else if (clr_sticky) begin
         sticky_d = 1'b0;
      end
   end

   // rst gates the handshake and write strobe so that a command caught by
   // reset can neither be accepted nor land in the register file
   assign cmd_ready    = (state_q == IDLE) && !rst;
   assign rf_wr        = (state_q == WRITE) && !nowb_q && !rst;
   assign done         = (state_q == WRITE) && !rst;
   assign rf_addr1     = addr1_q;
   assign rf_addr2     = addr2_q;
   assign rf_addr3     = addr3_q;
   assign rf_data3     = data3_q;
   assign alu_control  = ctrl_q;
   assign res_data     = res_data_q;
   assign res_zero     = res_zero_q;
   assign res_overflow = res_ovf_q;
   assign sticky_ovf   = sticky_q;
   assign ops_done     = cnt_q;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Bench for alu_rf_sequencer: a behavioural regfile + ALU environment around
// the DUT, and a command-level reference model of the architectural state.
module tb_alu_rf_sequencer;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_ready, cmd_type, cmd_nowb;
   logic [1:0]  cmd_src1, cmd_src2, cmd_dst, rf_addr1, rf_addr2, rf_addr3;
   logic [2:0]  cmd_op, alu_control;
   logic [31:0] cmd_imm, rf_data3, alu_result, res_data;
   logic        rf_wr, alu_zero, alu_overflow, done, res_zero, res_overflow;
   logic        sticky_ovf, clr_sticky;
   logic [15:0] ops_done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // environment: register file and ALU that the sequencer drives
   logic [31:0] env_rf [4] = '{default: 32'h0};
   logic [31:0] env_a, env_b;

   // reference model state, updated one whole command at a time
   logic [31:0] ref_rf [4] = '{default: 32'h0};
   logic        ref_sticky = 1'b0;
   int          ref_ops    = 0;

   alu_rf_sequencer #(.DATA_W(32), .ADDR_W(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
      .cmd_dst(cmd_dst), .cmd_op(cmd_op), .cmd_imm(cmd_imm), .cmd_nowb(cmd_nowb),
      .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_addr3(rf_addr3),
      .rf_data3(rf_data3), .rf_wr(rf_wr), .alu_control(alu_control),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .done(done), .res_data(res_data), .res_zero(res_zero),
      .res_overflow(res_overflow), .sticky_ovf(sticky_ovf),
      .clr_sticky(clr_sticky), .ops_done(ops_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rf_wr) env_rf[rf_addr3] <= rf_data3;

   always_comb begin
      env_a        = env_rf[rf_addr1];
      env_b        = env_rf[rf_addr2];
      alu_overflow = 1'b0;
      case (alu_control)
         3'b000: begin
            alu_result   = env_a + env_b;
            alu_overflow = ~(env_a[31] ^ env_b[31]) & (alu_result[31] ^ env_a[31]);
         end
         3'b001: begin
            alu_result   = env_a - env_b;
            alu_overflow = (env_a[31] ^ env_b[31]) & (alu_result[31] ^ env_a[31]);
         end
         3'b010:  alu_result = env_a & env_b;
         3'b011:  alu_result = env_a ^ env_b;
         default: alu_result = env_a | env_b;
      endcase
      alu_zero = (alu_result == 32'h0);
   end

   // command-level model: result, flags and whether the destination is written
   function automatic void ref_cmd(input logic typ, input logic [1:0] dst, s1, s2,
                                   input logic [2:0] op, input logic [31:0] imm,
                                   input logic nowb, output logic [31:0] r,
                                   output logic z, output logic v, output logic wr);
      longint s;
      logic [31:0] a, b;
      a = ref_rf[s1];
      b = ref_rf[s2];
      v = 1'b0;
      if (!typ) begin
         r = imm; z = 1'b0; wr = 1'b1;
      end else begin
         case (op)
            3'd0: begin s = longint'($signed(a)) + longint'($signed(b)); r = s[31:0];
                        v = (s != longint'($signed(r))); end
            3'd1: begin s = longint'($signed(a)) - longint'($signed(b)); r = s[31:0];
                        v = (s != longint'($signed(r))); end
            3'd2:    r = a & b;
            3'd3:    r = a ^ b;
            default: r = a | b;
         endcase
         z  = (r == 0);
         wr = !nowb;
         if (v) ref_sticky = 1'b1;
      end
      if (wr) ref_rf[dst] = r;
      ref_ops++;
   endfunction

   // drives one command and records what the DUT did, cycle index 1 = cycle after accept
   task automatic send_cmd(input logic typ, input logic [1:0] dst, s1, s2,
                           input logic [2:0] op, input logic [31:0] imm, input logic nowb,
                           output int acc, output int didx, output int dcnt, output int wcnt,
                           output logic [1:0] daddr, output logic [31:0] ddata,
                           output logic [2:0] dctl, output int iidx);
      acc = -1; didx = -1; dcnt = 0; wcnt = 0; daddr = 0; ddata = 0; dctl = 0; iidx = -1;
      cmd_type = typ; cmd_dst = dst; cmd_src1 = s1; cmd_src2 = s2;
      cmd_op = op; cmd_imm = imm; cmd_nowb = nowb; cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
      if (!cmd_ready) begin
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      cmd_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (done) begin
            dcnt++;
            if (didx < 0) begin
               didx = i; daddr = rf_addr3; ddata = rf_data3; dctl = alu_control;
            end
         end
         if (rf_wr) wcnt++;
         if (cmd_ready) begin
            iidx = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; cmd_valid = 1'b1; cmd_type = 1'b0; cmd_dst = 2'd3; cmd_imm = 32'hDEAD;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cmd_ready); end
         checks++;
         if ({rf_wr, done} !== 2'b00) begin errors++; $display("FAIL reset_wr_done got %b exp 00", {rf_wr, done}); end
         checks++;
         if (ops_done !== 16'd0 || sticky_ovf !== 1'b0) begin
            errors++; $display("FAIL reset_cnt_sticky got %h/%b exp 0/0", ops_done, sticky_ovf);
         end
         checks++;
         if ({rf_addr1, rf_addr2, rf_addr3, alu_control, rf_data3, res_data, res_zero, res_overflow} !== '0) begin
            errors++; $display("FAIL reset_regs got %h/%h/%h exp 0", rf_addr3, rf_data3, res_data);
         end
      end
      rst = 1'b0; cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", cmd_ready); end
      checks++;
      if (ops_done !== 16'd0 || env_rf[3] !== 32'h0) begin
         errors++; $display("FAIL reset_no_accept got %h/%h exp 0/0", ops_done, env_rf[3]);
      end
   endtask

   task automatic test_loads;
      logic [31:0] v [4] = '{32'd10, 32'd5, 32'd0, 32'd1};
      logic [31:0] r; logic z, o, wr;
      int acc, didx, dcnt, wcnt, iidx, prev;
      logic [1:0] daddr; logic [31:0] ddata; logic [2:0] dctl;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         send_cmd(1'b0, 2'(i), 2'd0, 2'd0, 3'd0, v[i], 1'b0, acc, didx, dcnt, wcnt, daddr, ddata, dctl, iidx);
         ref_cmd(1'b0, 2'(i), 2'd0, 2'd0, 3'd0, v[i], 1'b0, r, z, o, wr);
         checks++;
         if (didx !== 1 || dcnt !== 1 || wcnt !== 1 || iidx !== 2) begin
            errors++; $display("FAIL load_timing got done@%0d x%0d wr x%0d idle@%0d exp 1 1 1 2", didx, dcnt, wcnt, iidx);
         end
         checks++;
         if (daddr !== 2'(i) || ddata !== r) begin
            errors++; $display("FAIL load_write got R%0d=%h exp R%0d=%h", daddr, ddata, i, r);
         end
         checks++;
         if (res_data !== r || res_zero !== 1'b0 || res_overflow !== 1'b0) begin
            errors++; $display("FAIL load_res got %h z%b o%b exp %h z0 o0", res_data, res_zero, res_overflow, r);
         end
         if (i > 0) begin
            checks++;
            if (acc - prev !== 2) begin errors++; $display("FAIL load_spacing got %0d exp 2", acc - prev); end
         end
         prev = acc;
      end
      checks++;
      if (ops_done !== 16'd4) begin errors++; $display("FAIL load_count got %0d exp 4", ops_done); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (env_rf[i] !== ref_rf[i]) begin
            errors++; $display("FAIL load_rf%0d got %h exp %h", i, env_rf[i], ref_rf[i]);
         end
      end
   endtask

   task automatic test_alu;
      // typ, dst, src1, src2, op, imm
      logic        t  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0]  d  [8] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1};
      logic [1:0]  a  [8] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
      logic [1:0]  b  [8] = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
      logic [2:0]  op [8] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
      logic [31:0] im [8] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h7FFFFFFF, 32'h0, 32'h55};
      logic [31:0] r; logic z, o, wr;
      int acc, didx, dcnt, wcnt, iidx;
      logic [1:0] daddr; logic [31:0] ddata; logic [2:0] dctl;
      for (int i = 0; i < 8; i++) begin
         send_cmd(t[i], d[i], a[i], b[i], op[i], im[i], 1'b0, acc, didx, dcnt, wcnt, daddr, ddata, dctl, iidx);
         ref_cmd(t[i], d[i], a[i], b[i], op[i], im[i], 1'b0, r, z, o, wr);
         checks++;
         if (didx !== (t[i] ? 3 : 1) || dcnt !== 1 || wcnt !== 1 || iidx !== (t[i] ? 4 : 2)) begin
            errors++; $display("FAIL alu_timing[%0d] got done@%0d x%0d wr x%0d idle@%0d", i, didx, dcnt, wcnt, iidx);
         end
         checks++;
         if (daddr !== d[i] || ddata !== r) begin
            errors++; $display("FAIL alu_write[%0d] got R%0d=%h exp R%0d=%h", i, daddr, ddata, d[i], r);
         end
         checks++;
         if (res_data !== r || res_zero !== z || res_overflow !== o) begin
            errors++; $display("FAIL alu_res[%0d] got %h z%b o%b exp %h z%b o%b", i, res_data, res_zero, res_overflow, r, z, o);
         end
         checks++;
         if (sticky_ovf !== ref_sticky || ops_done !== 16'(ref_ops)) begin
            errors++; $display("FAIL alu_state[%0d] got s%b n%0d exp s%b n%0d", i, sticky_ovf, ops_done, ref_sticky, ref_ops);
         end
      end
      checks++;
      if (env_rf[3] !== 32'h80000000 || sticky_ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_result got %h s%b exp 80000000 s1", env_rf[3], sticky_ovf);
      end
      clr_sticky = 1'b1;
      @(negedge clk);
      clr_sticky = 1'b0;
      ref_sticky = 1'b0;
      checks++;
      if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL clr_sticky got %b exp 0", sticky_ovf); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] r; logic z, o, wr;
      logic [31:0] r2; logic z2, o2, wr2;
      int wcnt, dat;
      cmd_type = 1'b1; cmd_dst = 2'd2; cmd_src1 = 2'd2; cmd_src2 = 2'd2;
      cmd_op = 3'd3; cmd_imm = 32'h0; cmd_nowb = 1'b1; cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
      ref_cmd(1'b1, 2'd2, 2'd2, 2'd2, 3'd3, 32'h0, 1'b1, r, z, o, wr);
      @(posedge clk);
      wcnt = 0; dat = -1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (rf_wr) wcnt++;
         if (done && dat < 0) dat = i;
         checks++;
         if (cmd_ready !== (i == 4)) begin errors++; $display("FAIL hold_ready@%0d got %b exp %b", i, cmd_ready, i == 4); end
      end
      checks++;
      if (wcnt !== 0 || dat !== 3) begin errors++; $display("FAIL nowb got wr x%0d done@%0d exp 0 3", wcnt, dat); end
      checks++;
      if (res_data !== r || res_zero !== z || env_rf[2] !== ref_rf[2]) begin
         errors++; $display("FAIL nowb_res got %h z%b R2=%h exp %h z%b R2=%h", res_data, res_zero, env_rf[2], r, z, ref_rf[2]);
      end
      // second command offered without dropping valid, accepted at the edge ending T+4
      cmd_type = 1'b0; cmd_dst = 2'd1; cmd_imm = 32'h1234; cmd_nowb = 1'b0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      ref_cmd(1'b0, 2'd1, 2'd0, 2'd0, 3'd0, 32'h1234, 1'b0, r2, z2, o2, wr2);
      @(negedge clk);
      checks++;
      if (rf_wr !== 1'b1 || done !== 1'b1 || rf_data3 !== r2) begin
         errors++; $display("FAIL hold_second got wr%b d%b %h exp wr1 d1 %h", rf_wr, done, rf_data3, r2);
      end
      @(negedge clk);
      checks++;
      if (ops_done !== 16'(ref_ops) || env_rf[1] !== ref_rf[1]) begin
         errors++; $display("FAIL hold_count got %0d %h exp %0d %h", ops_done, env_rf[1], ref_ops, ref_rf[1]);
      end
   endtask

   task automatic test_reset_mid;
      int wcnt;
      cmd_type = 1'b1; cmd_dst = 2'd3; cmd_src1 = 2'd0; cmd_src2 = 2'd3;
      cmd_op = 3'd0; cmd_nowb = 1'b0; cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wcnt = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      if (rf_wr) wcnt++;
      checks++;
      if (cmd_ready !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL mid_rst_ctrl got r%b d%b exp r0 d0", cmd_ready, done);
      end
      rst = 1'b0;
      ref_ops = 0;
      ref_sticky = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rf_wr) wcnt++;
      end
      checks++;
      if (wcnt !== 0 || env_rf[3] !== ref_rf[3]) begin
         errors++; $display("FAIL mid_rst_write got wr x%0d R3=%h exp 0 %h", wcnt, env_rf[3], ref_rf[3]);
      end
      checks++;
      if (cmd_ready !== 1'b1 || ops_done !== 16'd0 || sticky_ovf !== 1'b0 || res_data !== 32'h0 || rf_addr3 !== 2'd0) begin
         errors++; $display("FAIL mid_rst_state got r%b n%0d s%b %h exp r1 n0 s0 0", cmd_ready, ops_done, sticky_ovf, res_data);
      end
   endtask

   task automatic test_random;
      logic typ, nowb; logic [1:0] dst, s1, s2; logic [2:0] op; logic [31:0] imm;
      logic [31:0] edge_v [4] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h1};
      logic [31:0] r; logic z, o, wr;
      int acc, didx, dcnt, wcnt, iidx;
      logic [1:0] daddr; logic [31:0] ddata; logic [2:0] dctl;
      for (int n = 0; n < 40; n++) begin
         typ  = 1'($urandom_range(0, 1));
         dst  = 2'($urandom_range(0, 3));
         s1   = 2'($urandom_range(0, 3));
         s2   = 2'($urandom_range(0, 3));
         op   = 3'($urandom_range(0, 4));
         nowb = ($urandom_range(0, 3) == 0);
         imm  = ($urandom_range(0, 1) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
         send_cmd(typ, dst, s1, s2, op, imm, nowb, acc, didx, dcnt, wcnt, daddr, ddata, dctl, iidx);
         ref_cmd(typ, dst, s1, s2, op, imm, nowb, r, z, o, wr);
         checks++;
         if (didx !== (typ ? 3 : 1) || dcnt !== 1 || wcnt !== (wr ? 1 : 0) || iidx !== (typ ? 4 : 2)) begin
            errors++; $display("FAIL rnd_timing[%0d] got done@%0d x%0d wr x%0d idle@%0d", n, didx, dcnt, wcnt, iidx);
         end
         checks++;
         if (daddr !== dst || ddata !== r || dctl !== op) begin
            errors++; $display("FAIL rnd_out[%0d] got R%0d=%h c%0d exp R%0d=%h c%0d", n, daddr, ddata, dctl, dst, r, op);
         end
         checks++;
         if (res_data !== r || res_zero !== z || res_overflow !== o || sticky_ovf !== ref_sticky) begin
            errors++; $display("FAIL rnd_res[%0d] got %h z%b o%b s%b exp %h z%b o%b s%b", n,
                               res_data, res_zero, res_overflow, sticky_ovf, r, z, o, ref_sticky);
         end
         checks++;
         if (ops_done !== 16'(ref_ops)) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", n, ops_done, ref_ops); end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (env_rf[i] !== ref_rf[i]) begin
            errors++; $display("FAIL rnd_rf%0d got %h exp %h", i, env_rf[i], ref_rf[i]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_type = 1'b0; cmd_nowb = 1'b0;
      cmd_src1 = 2'd0; cmd_src2 = 2'd0; cmd_dst = 2'd0; cmd_op = 3'd0;
      cmd_imm = 32'h0; clr_sticky = 1'b0;
      test_reset();
      test_loads();
      test_alu();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_rf_sequencer.md
# alu_rf_sequencer

Command-driven controller that sequences the 4-entry register file and the 32-bit ALU as a tiny load/execute engine. It accepts one command at a time over a valid/ready handshake: either a load-immediate into a register, or an ALU operation Rdst ← Rsrc1 op Rsrc2. It drives the regfile read/write ports and the ALU control, captures the result and flags, and reports completion. It replaces the hand-timed write/compute tasks that benches use today.

## Interface
- DATA_W, 32, datapath width; matches regfile and ALU
- ADDR_W, 2, register address width (4 registers)
- CNT_W, 16, width of completed-command counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept (IDLE only)
- cmd_type  in  1  0 = load immediate, 1 = ALU op
- cmd_src1, cmd_src2  in  ADDR_W  ALU source registers (ignored for load)
- cmd_dst  in  ADDR_W  destination register
- cmd_op  in  3  ALU control code: 000 add, 001 sub, 010 and, 011 xor; others passed through unchanged
- cmd_imm  in  DATA_W  immediate for load
- cmd_nowb  in  1  ALU op only: compute and report, suppress writeback
- rf_addr1, rf_addr2, rf_addr3  out  ADDR_W  regfile read/write addresses
- rf_data3  out  DATA_W  regfile write data
- rf_wr  out  1  regfile write enable, one-cycle pulse
- alu_control  out  3  to ALU ALUControl
- alu_result  in  DATA_W  ALU Result (combinational from rf data1/data2)
- alu_zero, alu_overflow  in  1  ALU Zero / Overflow
- done  out  1  one-cycle pulse: command complete
- res_data  out  DATA_W  last written/computed value
- res_zero, res_overflow  out  1  flags of last ALU op (cleared by load)
- sticky_ovf  out  1  set by any ALU overflow, held until clr_sticky
- clr_sticky  in  1  clears sticky_ovf
- ops_done  out  CNT_W  completed-command count, wraps

## Operation
- States: IDLE, READ, EXEC, WRITE.
- IDLE: cmd_ready=1. On cmd_valid: latch all command fields. The latched fields drive rf_addr1/2/3 and alu_control. ALU op → READ. Load → WRITE with rf_data3=cmd_imm.
- READ: addresses stable; regfile and ALU settle. Always → EXEC.
- EXEC: capture alu_result into rf_data3/res_data. Capture alu_zero and alu_overflow into res_zero and res_overflow. Set sticky_ovf if alu_overflow. → WRITE.
- WRITE: rf_wr=1 unless latched nowb; done=1; ops_done += 1 (wraps to 0 from all-ones). Load also sets res_data=imm, res_zero=0, res_overflow=0. → IDLE.
- rf_wr is asserted only in WRITE. The write lands on the regfile at the clock edge ending WRITE.
- Source and destination may alias (e.g. R2 ← R2 xor R2). Reads finish before the write, so there is no hazard. The next command always reads the updated value.
- clr_sticky and an overflow capture in the same cycle: set wins.
- Outputs change only at clock edges. rf_addr*/alu_control hold their last values in IDLE.

## Timing
- Handshake: accept on the edge where cmd_valid && cmd_ready. cmd_ready is low from the cycle after accept until the state returns to IDLE. cmd_valid held while busy is not consumed twice.
- ALU op: accept at edge T. READ in cycle T+1, EXEC in T+2, WRITE in T+3 (rf_wr=1, done=1), IDLE in T+4. Throughput is 4 cycles/command.
- Load: accept at edge T. WRITE in T+1, IDLE in T+2. Throughput is 2 cycles/command.
- Reset values: state IDLE, cmd_ready=1 (in cycles after reset releases), rf_wr=0, done=0, rf_addr*=0, rf_data3=0, alu_control=000, res_*=0, sticky_ovf=0, ops_done=0.
- rst while rst=1: cmd_ready=0.
- Reset mid-command (any state) takes effect at the next edge. rf_wr=0 from that cycle, the command is dropped, and the destination is not written.

## Test plan
- Reset: hold rst 2 cycles with cmd_valid=1 → cmd_ready=0 during reset, rf_wr=0, ops_done=0, sticky_ovf=0. No command is accepted until rst=0.
- Loads R0←10, R1←5, R2←0, R3←1 back-to-back → each rf_wr pulses exactly 1 cycle after accept with matching rf_addr3/rf_data3. Commands are accepted every 2 cycles; ops_done=4.
- R0 ← R1+R2 (add) → rf_wr 3 cycles after accept, rf_data3=5, res_zero=0. Then R1 ← R2 and R3 → res_data=0, res_zero=1.
- R1←0, R3←1, R2 ← R1−R3 → 0xFFFFFFFF. Then R0←0x7FFFFFFF, R3 ← R0+R3 → 0x80000000, res_overflow=1, sticky_ovf=1. Sticky persists through a later load; clr_sticky clears it.
- cmd_valid held high through an ALU op with nowb=1, R2 xor R2 → rf_wr stays 0, done pulses, res_zero=1. The second command is accepted only at T+4.
- rst pulsed while in EXEC of R3 ← R0+R3 → no rf_wr, R3 keeps its old value, state IDLE, ops_done=0.
